// File: rtl/uart_rx_err_monitor.sv
// rtl/uart_rx_err_monitor.sv - UART RX overrun/frame/parity/break error monitor
module uart_rx_err_monitor #(
  parameter int CNT_W      = 8,
  parameter bit OVR_STICKY = 1'b1,
  parameter bit ERR_STICKY = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rx_done,
  input  logic             i_rx_fifo_full,
  input  logic             i_frame_err,
  input  logic             i_parity_err,
  input  logic             i_break,
  input  logic [3:0]       i_flag_clr,
  input  logic             i_cnt_clr,
  input  logic [3:0]       i_irq_en,
  output logic [3:0]       o_err_flags,
  output logic [CNT_W-1:0] o_cnt_ovr,
  output logic [CNT_W-1:0] o_cnt_frm,
  output logic [CNT_W-1:0] o_cnt_par,
  output logic [CNT_W-1:0] o_cnt_brk,
  output logic             o_drop,
  output logic             o_irq
);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_OVERRUN = 2'd1,
    ST_LATCHED = 2'd2
  } ovr_state_t;

  ovr_state_t       state_q, state_d;
  logic             ovr_evt;
  logic [2:0]       err_evt;   // [0] frame [1] parity [2] break
  logic [2:0]       err_q;
  logic [3:0]       cnt_evt;   // [0] overrun [1] frame [2] parity [3] break
  logic [CNT_W-1:0] cnt_q [4];
  logic             drop_q;

  assign ovr_evt = i_rx_done & i_rx_fifo_full;
  assign err_evt = {i_break, i_parity_err, i_frame_err} & {3{i_rx_done}};
  assign cnt_evt = {err_evt, ovr_evt};

  // Overrun state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_NORMAL;
    else       state_q <= state_d;
  end

  // Overrun next-state: a fresh overrun beats a software clear while latched
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL:  if (ovr_evt) state_d = ST_OVERRUN;
      ST_OVERRUN: if (!i_rx_fifo_full) state_d = OVR_STICKY ? ST_LATCHED : ST_NORMAL;
      ST_LATCHED: begin
        if (ovr_evt)            state_d = ST_OVERRUN;
        else if (i_flag_clr[0]) state_d = ST_NORMAL;
      end
      default:    state_d = ST_NORMAL;
    endcase
  end

  // Frame/parity/break flags: sticky with set-over-clear, or single-cycle pulses
  always_ff @(posedge i_clk) begin
    if (i_rst)           err_q <= '0;
    else if (ERR_STICKY) err_q <= err_evt | (err_q & ~i_flag_clr[3:1]);
    else                 err_q <= err_evt;
  end

  // Drop pulse: one per byte that arrived with the FIFO full
  always_ff @(posedge i_clk) begin
    if (i_rst) drop_q <= 1'b0;
    else       drop_q <= ovr_evt;
  end

  // Saturating counters; an event coinciding with a clear leaves a count of one
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_rst)
        cnt_q[i] <= '0;
      else if (i_cnt_clr)
        cnt_q[i] <= cnt_evt[i] ? CNT_W'(1) : '0;
      else if (cnt_evt[i] && (cnt_q[i] != {CNT_W{1'b1}}))
        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
    end
  end

  assign o_err_flags = {err_q, (state_q != ST_NORMAL)};
  assign o_drop      = drop_q;
  assign o_irq       = |(o_err_flags & i_irq_en);
  assign o_cnt_ovr   = cnt_q[0];
  assign o_cnt_frm   = cnt_q[1];
  assign o_cnt_par   = cnt_q[2];
  assign o_cnt_brk   = cnt_q[3];

endmodule
